// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV32I pipeline.
// Drives a ready-handshaked data-memory port from the EX/MEM register,
// aligns store data / byte enables, extracts and extends load data and
// produces the registered MEM/WB-side results plus the pipeline stall.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that waits
// TIMEOUT_CYCLES BUSY cycles without dmem_ready (bus_err pulse, bubble).
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  // control and data from EX/MEM
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic        zero_in,
  input  logic [31:0] branch_target_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  // data-memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  // pipeline control
  output logic        mem_stall,
  output logic        pc_src,
  output logic [31:0] pc_branch_target,
  output logic        misalign_err,
  output logic        bus_err,
  // MEM/WB side
  output logic        wb_RegWrite,
  output logic        wb_MemToReg,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state_reg;
  logic [0:0]  state_next;

  // decode of the incoming instruction
  logic        access;
  logic        size_byte;
  logic        size_half;
  logic        misaligned;
  logic        issue;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // copy of the accepted access, kept stable while BUSY
  logic        we_hold_reg;
  logic        load_hold_reg;
  logic [3:0]  be_hold_reg;
  logic [31:0] wdata_hold_reg;
  logic [2:0]  f3_hold_reg;
  logic        rw_hold_reg;
  logic        m2r_hold_reg;
  logic [31:0] alu_hold_reg;
  logic [4:0]  rd_hold_reg;

  // load extraction from the returned word
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;

  logic        timeout_hit;

  assign access     = MemRead_in | MemWrite_in;
  assign size_byte  = (funct3_in[1:0] == 2'b00);
  assign size_half  = (funct3_in[1:0] == 2'b01);
  // halfwords need an even address, words need a 4-byte aligned address
  assign misaligned = access &
                      ((size_half & alu_result_in[0]) |
                       (~size_byte & ~size_half & (|alu_result_in[1:0])));
  assign issue      = (state_reg == IDLE) & access & ~misaligned;

  // Branch resolution does not depend on the memory FSM.
  assign pc_src           = Branch_in & zero_in;
  assign pc_branch_target = branch_target_in;

  // Store lanes: bytes go to every lane, halves to both half-words, words as-is,
  // so the byte enables alone select where the data lands.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_calc[gi*8 +: 8] = size_byte ? rs2_data_in[7:0] :
                                     size_half ? rs2_data_in[(gi % 2)*8 +: 8] :
                                                 rs2_data_in[gi*8 +: 8];
    end
  endgenerate

  // Byte enables: stores select lanes by size and offset, loads read the full word.
  always_comb begin
    be_calc = 4'b1111;
    if (MemWrite_in) begin
      if (size_byte) begin
        be_calc = 4'b0001 << alu_result_in[1:0];
      end else if (size_half) begin
        be_calc = alu_result_in[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  assign byte_val = dmem_rdata[{alu_hold_reg[1:0], 3'b000} +: 8];
  assign half_val = alu_hold_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  // Load result: pick the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    case (f3_hold_reg[1:0])
      2'b00:   load_data = {{24{~f3_hold_reg[2] & byte_val[7]}}, byte_val};
      2'b01:   load_data = {{16{~f3_hold_reg[2] & half_val[15]}}, half_val};
      default: load_data = dmem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [31:0] to_cnt_reg;
  logic        bus_err_reg;

  assign timeout_hit = (state_reg == BUSY) & ~dmem_ready &
                       (to_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign bus_err     = bus_err_reg;

  // Count unanswered BUSY cycles; cleared whenever the FSM leaves BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_reg  <= 32'd0;
      bus_err_reg <= 1'b0;
    end else begin
      bus_err_reg <= timeout_hit;
      if ((state_reg == BUSY) && (state_next == BUSY)) begin
        to_cnt_reg <= to_cnt_reg + 32'd1;
      end else begin
        to_cnt_reg <= 32'd0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // Bus drive, stall and next state. IDLE drives the request straight from the
  // inputs so an access issues in its first cycle; BUSY replays the held copy.
  always_comb begin
    state_next = state_reg;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    dmem_be    = 4'd0;
    mem_stall  = 1'b0;
    if (state_reg == IDLE) begin
      if (issue) begin
        dmem_req   = 1'b1;
        dmem_we    = MemWrite_in;
        dmem_addr  = {alu_result_in[31:2], 2'b00};
        dmem_wdata = wdata_calc;
        dmem_be    = be_calc;
        mem_stall  = 1'b1;
        state_next = BUSY;
      end
    end else begin
      if (timeout_hit) begin
        state_next = IDLE;
      end else begin
        dmem_req   = 1'b1;
        dmem_we    = we_hold_reg;
        dmem_addr  = {alu_hold_reg[31:2], 2'b00};
        dmem_wdata = wdata_hold_reg;
        dmem_be    = be_hold_reg;
        mem_stall  = ~dmem_ready;
        if (dmem_ready) begin
          state_next = IDLE;
        end
      end
    end
    // Reset is asynchronous, so the request and stall must drop with it.
    if (reset) begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'd0;
      dmem_wdata = 32'd0;
      dmem_be    = 4'd0;
      mem_stall  = 1'b0;
    end
  end

  // FSM state, held access copy, error pulse and MEM/WB results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      we_hold_reg    <= 1'b0;
      load_hold_reg  <= 1'b0;
      be_hold_reg    <= 4'd0;
      wdata_hold_reg <= 32'd0;
      f3_hold_reg    <= 3'd0;
      rw_hold_reg    <= 1'b0;
      m2r_hold_reg   <= 1'b0;
      alu_hold_reg   <= 32'd0;
      rd_hold_reg    <= 5'd0;
      misalign_err   <= 1'b0;
      wb_RegWrite    <= 1'b0;
      wb_MemToReg    <= 1'b0;
      wb_mem_data    <= 32'd0;
      wb_alu_result  <= 32'd0;
      wb_rd          <= 5'd0;
    end else begin
      state_reg    <= state_next;
      misalign_err <= (state_reg == IDLE) & misaligned;

      if (issue) begin
        we_hold_reg    <= MemWrite_in;
        load_hold_reg  <= MemRead_in;
        be_hold_reg    <= be_calc;
        wdata_hold_reg <= wdata_calc;
        f3_hold_reg    <= funct3_in;
        rw_hold_reg    <= RegWrite_in;
        m2r_hold_reg   <= MemToReg_in;
        alu_hold_reg   <= alu_result_in;
        rd_hold_reg    <= rd_in;
      end

      if (mem_stall) begin
        // stalled cycle: send a bubble, keep the data fields
        wb_RegWrite <= 1'b0;
        wb_MemToReg <= 1'b0;
      end else if (state_reg == BUSY) begin
        // access finished (or timed out): retire the held instruction
        wb_RegWrite   <= rw_hold_reg & ~timeout_hit;
        wb_MemToReg   <= m2r_hold_reg;
        wb_alu_result <= alu_hold_reg;
        wb_rd         <= rd_hold_reg;
        wb_mem_data   <= (load_hold_reg & ~timeout_hit) ? load_data : 32'd0;
      end else begin
        // single-cycle pass-through; a misaligned access retires as a bubble
        wb_RegWrite   <= RegWrite_in & ~misaligned;
        wb_MemToReg   <= MemToReg_in;
        wb_alu_result <= alu_result_in;
        wb_rd         <= rd_in;
        wb_mem_data   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vectors, expected results queued at issue
// time and popped by a monitor on every retirement / memory acceptance.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, Branch_in;
  logic [31:0] alu_result_in, rs2_data_in, branch_target_in;
  logic        zero_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        mem_stall, pc_src, misalign_err, bus_err;
  logic [31:0] pc_branch_target;
  logic        wb_RegWrite, wb_MemToReg;
  logic [31:0] wb_mem_data, wb_alu_result;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .Branch_in(Branch_in), .alu_result_in(alu_result_in),
    .rs2_data_in(rs2_data_in), .zero_in(zero_in), .branch_target_in(branch_target_in),
    .rd_in(rd_in), .funct3_in(funct3_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .pc_src(pc_src), .pc_branch_target(pc_branch_target),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_mem_data(wb_mem_data),
    .wb_alu_result(wb_alu_result), .wb_rd(wb_rd)
  );

  typedef struct {
    logic        rw, m2r, mr, mw;
    logic [2:0]  f3;
    logic [31:0] addr, rs2;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          wait_n;     // BUSY cycles before ready; -1 = never
    bit          rdy_idle;   // drive ready in the IDLE cycle (must be ignored)
    logic        exp_rw;
    logic [31:0] exp_mem;
    int          exp_stalls;
    logic        exp_mis, exp_berr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic rw; logic m2r; logic [4:0] rd; logic [31:0] alu; logic [31:0] mem;
    int stalls; logic mis; logic berr;
  } wb_exp_t;

  typedef struct {
    logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];
  vec_t     vecs[$];
  int       checks = 0;
  int       errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  int       stall_acc = 0;
  int       ret_stalls = 0;
  bit       prev_valid = 1'b0;
  bit       prev_stall = 1'b0;
  logic     prev_req = 1'b0;
  logic     prev_ready = 1'b0;
  logic     p_we;
  logic [3:0]  p_be;
  logic [31:0] p_addr, p_wdata;
  wb_exp_t  me;
  bus_exp_t mb;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      stall_acc  = 0;
      prev_req   = 1'b0;
      prev_ready = 1'b0;
    end else begin
      // a non-stalled previous cycle means an instruction retired at the last edge
      if (prev_valid && !prev_stall && wb_q.size() > 0) begin
        me = wb_q.pop_front();
        $display("retire rd=%0d alu=%h mem=%h rw=%b stalls=%0d mis=%b berr=%b",
                 wb_rd, wb_alu_result, wb_mem_data, wb_RegWrite, ret_stalls, misalign_err, bus_err);
        chk("wb_RegWrite", 32'(wb_RegWrite), 32'(me.rw));
        chk("wb_MemToReg", 32'(wb_MemToReg), 32'(me.m2r));
        chk("wb_rd", 32'(wb_rd), 32'(me.rd));
        chk("wb_alu_result", wb_alu_result, me.alu);
        chk("wb_mem_data", wb_mem_data, me.mem);
        chk("stall_cycles", ret_stalls, me.stalls);
        chk("misalign_err", 32'(misalign_err), 32'(me.mis));
        chk("bus_err", 32'(bus_err), 32'(me.berr));
      end
      if (mem_stall) begin
        stall_acc++;
      end else begin
        ret_stalls = stall_acc;
        stall_acc  = 0;
      end
      prev_stall = mem_stall;
      prev_valid = 1'b1;

      // bus outputs must not move while a request waits for ready
      if (dmem_req && prev_req && !prev_ready) begin
        chk("bus_hold_addr", dmem_addr, p_addr);
        chk("bus_hold_wdata", dmem_wdata, p_wdata);
        chk("bus_hold_ctrl", 32'({dmem_we, dmem_be}), 32'({p_we, p_be}));
      end
      if (dmem_req && dmem_ready && prev_req) begin
        $display("accept we=%b addr=%h be=%b wdata=%h", dmem_we, dmem_addr, dmem_be, dmem_wdata);
        if (bus_q.size() == 0) begin
          chk("unexpected_access", 32'd1, 32'd0);
        end else begin
          mb = bus_q.pop_front();
          chk("dmem_we", 32'(dmem_we), 32'(mb.we));
          chk("dmem_addr", dmem_addr, mb.addr);
          chk("dmem_be", 32'(dmem_be), 32'(mb.be));
          chk("dmem_wdata", dmem_wdata, mb.wdata);
        end
      end
      prev_req   = dmem_req;
      prev_ready = dmem_ready;
      p_we = dmem_we; p_be = dmem_be; p_addr = dmem_addr; p_wdata = dmem_wdata;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    RegWrite_in   = v.rw;
    MemToReg_in   = v.m2r;
    MemRead_in    = v.mr;
    MemWrite_in   = v.mw;
    funct3_in     = v.f3;
    alu_result_in = v.addr;
    rs2_data_in   = v.rs2;
    rd_in         = v.rd;
    dmem_rdata    = v.rdata;
  endtask

  task automatic run_vec(input vec_t v);
    wb_exp_t  e;
    bus_exp_t b;
    bit       done;
    logic     st;
    done = 1'b0;
    drive(v);
    e.rw = v.exp_rw; e.m2r = v.m2r; e.rd = v.rd; e.alu = v.addr; e.mem = v.exp_mem;
    e.stalls = v.exp_stalls; e.mis = v.exp_mis; e.berr = v.exp_berr;
    wb_q.push_back(e);
    if ((v.mr | v.mw) && !v.exp_mis && !v.exp_berr) begin
      b.we = v.mw; b.addr = {v.addr[31:2], 2'b00}; b.be = v.exp_be; b.wdata = v.exp_wdata;
      bus_q.push_back(b);
    end
    for (int c = 0; c < 64 && !done; c++) begin
      dmem_ready = (c == 0) ? v.rdy_idle : ((v.wait_n >= 0) && (c == v.wait_n + 1));
      @(negedge clk);
      st = mem_stall;
      @(posedge clk);
      #1;
      if (!st) done = 1'b1;
    end
    dmem_ready = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL stall_bound actual=stuck required=release addr=%h", v.addr);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "stall never released");
    end
  endtask

  vec_t post;

  initial begin
    // fields: rw m2r mr mw f3 addr rs2 rd rdata wait rdy_idle | exp_rw exp_mem stalls mis berr be wdata
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'b010,32'h100,32'h0,5'd5,32'hDEADBEEF,0,1'b0, 1'b1,32'hDEADBEEF,1,1'b0,1'b0,4'hF,32'h0});        // LW
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'b000,32'h103,32'h0,5'd6,32'h80123456,0,1'b0, 1'b1,32'hFFFFFF80,1,1'b0,1'b0,4'hF,32'h0});        // LB
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'b100,32'h103,32'h0,5'd7,32'h80123456,0,1'b0, 1'b1,32'h00000080,1,1'b0,1'b0,4'hF,32'h0});        // LBU
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'b001,32'h102,32'h0,5'd8,32'h80017F00,0,1'b0, 1'b1,32'hFFFF8001,1,1'b0,1'b0,4'hF,32'h0});        // LH upper
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'b101,32'h100,32'h0,5'd9,32'h8001F00F,0,1'b0, 1'b1,32'h0000F00F,1,1'b0,1'b0,4'hF,32'h0});        // LHU lower
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,3'b001,32'h102,32'h1234ABCD,5'd0,32'h0,0,1'b0, 1'b0,32'h0,1,1'b0,1'b0,4'hC,32'hABCDABCD});       // SH
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,3'b000,32'h101,32'h000000A5,5'd0,32'h0,0,1'b0, 1'b0,32'h0,1,1'b0,1'b0,4'h2,32'hA5A5A5A5});       // SB
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,3'b010,32'h200,32'h11223344,5'd0,32'h0,2,1'b0, 1'b0,32'h0,3,1'b0,1'b0,4'hF,32'h11223344});       // SW, 2 waits
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'b010,32'h101,32'h0,5'd10,32'h0,0,1'b0, 1'b0,32'h0,0,1'b1,1'b0,4'h0,32'h0});                     // LW misaligned
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,3'b001,32'h103,32'hFFFF,5'd0,32'h0,0,1'b0, 1'b0,32'h0,0,1'b1,1'b0,4'h0,32'h0});                   // SH misaligned
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'b010,32'h104,32'h0,5'd11,32'hCAFEF00D,3,1'b0, 1'b1,32'hCAFEF00D,4,1'b0,1'b0,4'hF,32'h0});      // LW, 3 waits

    reset = 1'b1;
    RegWrite_in = 1'b0; MemToReg_in = 1'b0; MemRead_in = 1'b1; MemWrite_in = 1'b0;
    Branch_in = 1'b0; zero_in = 1'b0; branch_target_in = 32'h0;
    alu_result_in = 32'h100; rs2_data_in = 32'h0; rd_in = 5'd1; funct3_in = 3'b010;
    dmem_rdata = 32'h0; dmem_ready = 1'b0;

    // reset state, with an aligned load presented at the inputs
    repeat (2) @(posedge clk);
    #1;
    $display("reset req=%b stall=%b wb_rw=%b", dmem_req, mem_stall, wb_RegWrite);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_bus", {dmem_addr[27:0], dmem_be}, 32'd0);
    chk("rst_wdata_we", dmem_wdata | 32'(dmem_we), 32'd0);
    chk("rst_wb_ctrl", 32'({wb_RegWrite, wb_MemToReg, wb_rd, misalign_err, bus_err}), 32'd0);
    chk("rst_wb_data", wb_mem_data | wb_alu_result, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // branch resolution is combinational and independent of the FSM
    Branch_in = 1'b1; zero_in = 1'b1; branch_target_in = 32'h40;
    #1;
    $display("branch pc_src=%b target=%h", pc_src, pc_branch_target);
    chk("pc_src_taken", 32'(pc_src), 32'd1);
    chk("pc_branch_target", pc_branch_target, 32'h40);
    zero_in = 1'b0;
    #1;
    chk("pc_src_not_taken", 32'(pc_src), 32'd0);
    Branch_in = 1'b0;

    // ALU op with ready asserted (ignored), then a load with ready in its IDLE cycle
    run_vec('{1'b1,1'b0,1'b0,1'b0,3'b000,32'h55,32'h0,5'd12,32'h0,0,1'b1, 1'b1,32'h0,0,1'b0,1'b0,4'h0,32'h0});
    run_vec('{1'b1,1'b1,1'b1,1'b0,3'b010,32'h108,32'h0,5'd13,32'h13572468,0,1'b1, 1'b1,32'h13572468,1,1'b0,1'b0,4'hF,32'h0});
`ifdef MEM_TIMEOUT_EN
    // ready never comes: aborted after 4 BUSY cycles
    run_vec('{1'b1,1'b1,1'b1,1'b0,3'b010,32'h10C,32'h0,5'd14,32'h0,-1,1'b0, 1'b0,32'h0,4,1'b0,1'b1,4'hF,32'h0});
`endif

    // reset in the middle of a BUSY access
    RegWrite_in = 1'b1; MemToReg_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0;
    funct3_in = 3'b010; alu_result_in = 32'h300; rd_in = 5'd20; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("busy_req_before_reset", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    $display("midreset req=%b stall=%b wb_rw=%b wb_rd=%0d", dmem_req, mem_stall, wb_RegWrite, wb_rd);
    chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("midrst_mem_stall", 32'(mem_stall), 32'd0);
    chk("midrst_wb_ctrl", 32'({wb_RegWrite, wb_MemToReg, wb_rd}), 32'd0);
    chk("midrst_wb_data", wb_mem_data | wb_alu_result, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    post = '{1'b1,1'b1,1'b1,1'b0,3'b010,32'h110,32'h0,5'd15,32'h0BADF00D,1,1'b0, 1'b1,32'h0BADF00D,2,1'b0,1'b0,4'hF,32'h0};
    run_vec(post);

    // drain
    MemRead_in = 1'b0; MemWrite_in = 1'b0; RegWrite_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
